// File: rtl/multicycle_core.sv
// Four-state multicycle core: FETCH, DECODE, EXEC, WB (plus HALT), with a register file.
// Define MC_SHIFT_EN to build the SLL/SRL shifter; otherwise funct 5/6 retire as illegal.
module multicycle_core #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  output logic              halted,
  output logic [2:0]        state_dbg
);

  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] regs [NREG];

  logic [5:0]        op;
  logic [RW-1:0]     rd_idx;
  logic [RW-1:0]     rs_idx;
  logic [RW-1:0]     rt_idx;
  logic [4:0]        shamt;
  logic [2:0]        funct;
  logic              unused_bits;

  assign op          = ir[31:26];
  assign rd_idx      = ir[21 +: RW];
  assign rs_idx      = ir[16 +: RW];
  assign rt_idx      = ir[11 +: RW];
  assign shamt       = ir[10:6];
  assign funct       = ir[2:0];
  assign unused_bits = ^{ir[5:3], shamt};

  logic is_rtype, is_li, is_bnz, is_halt, r_legal, writes_reg, is_illegal;

  assign is_rtype = (op == 6'd0);
  assign is_li    = (op == 6'd1);
  assign is_bnz   = (op == 6'd2);
  assign is_halt  = (op == 6'd3);
`ifdef MC_SHIFT_EN
  assign r_legal  = 1'b1;
`else
  assign r_legal  = (funct != 3'd5) && (funct != 3'd6);
`endif
  assign writes_reg = (is_rtype && r_legal) || is_li;
  assign is_illegal = !(writes_reg || is_bnz || is_halt);

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_result;

  // imm21 is sign-extended to 64 bits first so the cast truncates cleanly for any DATA_W.
  assign imm_ext = DATA_W'({{43{ir[20]}}, ir[20:0]});

  always_comb begin
    alu_result = '0;
    if (is_li) begin
      alu_result = imm_ext;
    end else begin
      case (funct)
        3'd0: alu_result = a + b;
        3'd1: alu_result = a - b;
        3'd2: alu_result = a & b;
        3'd3: alu_result = a | b;
        3'd4: alu_result = a ^ b;
`ifdef MC_SHIFT_EN
        3'd5: alu_result = b << shamt;
        3'd6: alu_result = b >> shamt;
`endif
        3'd7: alu_result[0] = ($signed(a) < $signed(b));
        default: alu_result = '0;
      endcase
    end
  end

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] pc_branch;
  logic [PC_W-1:0] pc_next;

  assign pc_plus4  = pc + PC_W'(4);
  assign pc_branch = pc_plus4 + PC_W'({{46{ir[15]}}, ir[15:0], 2'b00});
  assign pc_next   = (is_bnz && (a != '0)) ? pc_branch : pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    wb_valid   = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = is_halt ? S_HALT : S_WB;
      S_WB: begin
        wb_valid   = writes_reg && (rd_idx != '0);
        illegal    = is_illegal;
        state_next = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_next = S_FETCH;
    endcase
    // Reset masks every strobe, whatever state the register still holds.
    if (rst) begin
      imem_req = 1'b0;
      wb_valid = 1'b0;
      illegal  = 1'b0;
      halted   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH:  if (imem_ack) ir <= imem_data;
        S_DECODE: begin
          a <= (rs_idx == '0) ? '0 : regs[rs_idx];
          b <= (rt_idx == '0) ? '0 : regs[rt_idx];
        end
        S_EXEC:   aluout <= alu_result;
        S_WB: begin
          pc <= pc_next;
          if (wb_valid) regs[rd_idx] <= aluout;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign wb_reg    = ir[25:21];
  assign wb_data   = aluout;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: ROM-backed fetch responder with programmable ack delay,
// writeback scoreboard, fetch-address log and illegal-pulse counter.
module tb_multicycle_core;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        illegal;
  logic        halted;
  logic [2:0]  state_dbg;

  multicycle_core dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .illegal   (illegal),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running sim, expected finish");
    $fatal(1);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // instruction memory model: ack after ack_delay wait cycles while imem_req is high
  logic [31:0] rom [64];
  int          ack_delay = 0;
  int          wait_cnt  = 0;

  assign imem_data = rom[imem_addr[7:2]];

  initial imem_ack = 1'b0;
  always @(posedge clk) begin
    #2;
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // scoreboard: expected {wb_reg, wb_data} in retire order
  logic [36:0] exp_q [$];
  logic [7:0]  fa_q [$];
  int          ill_cnt   = 0;
  bit          wb_chk_en = 1'b1;

  always @(negedge clk) begin
    logic [36:0] e;
    if (imem_req && imem_ack) fa_q.push_back(imem_addr);
    if (illegal) ill_cnt++;
    if (wb_valid && wb_chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("wb", {wb_reg, wb_data}, e);
    end
  end

  function automatic logic [31:0] enc_r(input logic [2:0] funct, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] shamt);
    return {6'd0, rd, rs, rt, shamt, 3'b000, funct};
  endfunction

  function automatic logic [31:0] enc_li(input logic [4:0] rd, input logic [20:0] imm);
    return {6'd1, rd, imm};
  endfunction

  function automatic logic [31:0] enc_bnz(input logic [4:0] rs, input logic [15:0] off);
    return {6'd2, 5'd0, rs, off};
  endfunction

  localparam logic [31:0] HALT_W = {6'd3, 26'd0};

  function automatic logic [7:0] fa(input int i);
    return (fa_q.size() > i) ? fa_q[i] : 8'hxx;
  endfunction

  // driver tasks
  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = HALT_W;
  endtask

  // Holds reset for two edges, checks the masked outputs, then releases just after a posedge.
  task automatic reset_core();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {imem_req, wb_valid, illegal, halted}, 4'b0000);
    check("rst_addr", imem_addr, 8'd0);
    fa_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic drain();
    check("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int ill0;
    rst = 1'b1;
    clear_rom();
    @(negedge clk);

    // LI sign extension and 4-cycle retire with zero-wait ack
    rom[0] = enc_li(5'd1, 21'h1FFFFB);
    exp_q.push_back({5'd1, 32'hFFFF_FFFB});
    reset_core();
    repeat (3) @(negedge clk);
    check("li_no_early_wb", wb_valid, 1'b0);
    @(negedge clk);
    check("li_wb_cycle4", {wb_valid, wb_reg, wb_data}, {1'b1, 5'd1, 32'hFFFF_FFFB});
    @(negedge clk);
    check("li_next_fetch", {imem_req, imem_addr}, {1'b1, 8'd4});
    wait_halt(100);
    check("halt_pc", imem_addr, 8'd4);
    drain();

    // ALU operations, R0 write suppression, illegal opcode
    clear_rom();
    rom[0]  = enc_li(5'd1, 21'd7);
    rom[1]  = enc_li(5'd2, 21'd3);
    rom[2]  = enc_r(3'd1, 5'd3, 5'd1, 5'd2, 5'd0);
    rom[3]  = enc_r(3'd7, 5'd4, 5'd2, 5'd1, 5'd0);
    rom[4]  = enc_r(3'd0, 5'd0, 5'd1, 5'd2, 5'd0);
    rom[5]  = enc_li(5'd5, 21'h1FFFFE);
    rom[6]  = enc_r(3'd7, 5'd6, 5'd5, 5'd1, 5'd0);
    rom[7]  = enc_r(3'd7, 5'd7, 5'd1, 5'd5, 5'd0);
    rom[8]  = enc_r(3'd2, 5'd8, 5'd1, 5'd2, 5'd0);
    rom[9]  = enc_r(3'd3, 5'd9, 5'd1, 5'd2, 5'd0);
    rom[10] = enc_r(3'd4, 5'd10, 5'd1, 5'd2, 5'd0);
    rom[11] = enc_r(3'd1, 5'd11, 5'd2, 5'd1, 5'd0);
    rom[12] = enc_r(3'd0, 5'd12, 5'd5, 5'd1, 5'd0);
    rom[13] = {6'd9, 26'h3FF_FFFF};
    rom[14] = enc_li(5'd13, 21'h0FFFFF);
    exp_q.push_back({5'd1, 32'd7});
    exp_q.push_back({5'd2, 32'd3});
    exp_q.push_back({5'd3, 32'd4});
    exp_q.push_back({5'd4, 32'd1});
    exp_q.push_back({5'd5, 32'hFFFF_FFFE});
    exp_q.push_back({5'd6, 32'd1});
    exp_q.push_back({5'd7, 32'd0});
    exp_q.push_back({5'd8, 32'd3});
    exp_q.push_back({5'd9, 32'd7});
    exp_q.push_back({5'd10, 32'd4});
    exp_q.push_back({5'd11, 32'hFFFF_FFFC});
    exp_q.push_back({5'd12, 32'd5});
    exp_q.push_back({5'd13, 32'h000F_FFFF});
    ill0 = ill_cnt;
    reset_core();
    wait_halt(400);
    check("alu_halt_pc", imem_addr, 8'd60);
    check("alu_illegal_cnt", ill_cnt - ill0, 1);
    drain();

    // three-cycle ack delay: request held, address stable, 7 cycles per instruction
    clear_rom();
    ack_delay = 3;
    rom[0] = enc_li(5'd1, 21'd5);
    exp_q.push_back({5'd1, 32'd5});
    reset_core();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("wait_req_hold", {imem_req, imem_addr}, {1'b1, 8'd0});
    end
    repeat (2) @(negedge clk);
    check("wait_no_early_wb", wb_valid, 1'b0);
    @(negedge clk);
    check("wait_wb_cycle7", {wb_valid, wb_data}, {1'b1, 32'd5});
    @(negedge clk);
    check("wait_next_fetch", {imem_req, imem_addr}, {1'b1, 8'd4});
    wait_halt(100);
    ack_delay = 0;
    drain();

    // branches: taken backward loop, not taken, wrap past top of PC space
    wb_chk_en = 1'b0;
    clear_rom();
    rom[0] = enc_li(5'd1, 21'd7);
    rom[1] = enc_li(5'd2, 21'd0);
    rom[2] = enc_bnz(5'd1, 16'hFFFF);
    reset_core();
    repeat (24) @(negedge clk);
    check("bnz_taken_f2", fa(2), 8'd8);
    check("bnz_taken_f3", fa(3), 8'd8);

    rom[0] = enc_li(5'd1, 21'd0);
    reset_core();
    repeat (24) @(negedge clk);
    check("bnz_fall_f3", fa(3), 8'd12);
    check("bnz_fall_halt", halted, 1'b1);

    clear_rom();
    rom[0]  = enc_li(5'd1, 21'd1);
    rom[1]  = enc_bnz(5'd1, 16'd61);
    rom[63] = enc_bnz(5'd1, 16'd0);
    reset_core();
    repeat (24) @(negedge clk);
    check("bnz_far_f2", fa(2), 8'd252);
    check("bnz_wrap_f3", fa(3), 8'd0);
    wb_chk_en = 1'b1;

    // shifts: legal with the shifter built, illegal otherwise
    clear_rom();
    rom[0] = enc_li(5'd3, 21'd3);
    rom[1] = enc_r(3'd5, 5'd5, 5'd0, 5'd3, 5'd4);
    rom[2] = enc_li(5'd7, 21'h100);
    rom[3] = enc_r(3'd6, 5'd6, 5'd0, 5'd7, 5'd4);
    exp_q.push_back({5'd3, 32'd3});
`ifdef MC_SHIFT_EN
    exp_q.push_back({5'd5, 32'd48});
`endif
    exp_q.push_back({5'd7, 32'h100});
`ifdef MC_SHIFT_EN
    exp_q.push_back({5'd6, 32'h10});
`endif
    ill0 = ill_cnt;
    reset_core();
    wait_halt(200);
    check("shift_halt_pc", imem_addr, 8'd16);
`ifdef MC_SHIFT_EN
    check("shift_illegal_cnt", ill_cnt - ill0, 0);
`else
    check("shift_illegal_cnt", ill_cnt - ill0, 2);
`endif
    drain();

    // HALT holds for 20 cycles
    clear_rom();
    rom[0] = enc_li(5'd1, 21'd9);
    exp_q.push_back({5'd1, 32'd9});
    reset_core();
    wait_halt(100);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("halt_hold", {halted, imem_req, wb_valid, imem_addr}, {3'b100, 8'd4});
    end
    drain();

    // reset asserted during EXEC of the second instruction clears registers and PC
    rom[1] = enc_li(5'd3, 21'd1);
    exp_q.push_back({5'd1, 32'd9});
    reset_core();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    rom[0] = enc_r(3'd0, 5'd2, 5'd1, 5'd1, 5'd0);
    #1;
    check("rst_mid_exec_strobes", {imem_req, wb_valid, illegal, halted}, 4'b0000);
    check("rst_mid_exec_drained", exp_q.size(), 0);
    exp_q.push_back({5'd2, 32'd0});
    exp_q.push_back({5'd3, 32'd1});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_refetch", {imem_req, imem_addr}, {1'b1, 8'd0});
    wait_halt(100);
    check("rst_halt_pc", imem_addr, 8'd8);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter DATA_W SHALL default to 32 and set the datapath and register width; legal values are 16 to 64.
REQ-002 Parameter PC_W SHALL default to 8 and set the PC and fetch address width; addresses are byte addresses, word aligned.
REQ-003 Parameter NREG SHALL default to 32 and set the register count (power of 2, at most 32); register index is the low log2(NREG) bits of each 5-bit field.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port imem_addr, output, PC_W bits: fetch address, equal to PC.
REQ-007 Port imem_req, output, 1 bit: fetch request.
REQ-008 Port imem_ack, input, 1 bit: imem_data is valid this cycle.
REQ-009 Port imem_data, input, 32 bits: instruction word.
REQ-010 Port wb_valid, output, 1 bit: one-cycle pulse on each register write.
REQ-011 Port wb_reg, output, 5 bits: destination index of the write.
REQ-012 Port wb_data, output, DATA_W bits: value written.
REQ-013 Port illegal, output, 1 bit: one-cycle pulse when an illegal instruction retires.
REQ-014 Port halted, output, 1 bit: high while in HALT.

Function
REQ-015 The core SHALL implement the states FETCH, DECODE, EXEC, WB and HALT; state encoding is free.
REQ-016 FETCH SHALL drive imem_req=1 until imem_ack is sampled 1, latch IR<=imem_data on that cycle, then go to DECODE; imem_ack SHALL be ignored outside FETCH.
REQ-017 Instruction fields SHALL be: op [31:26], rd [25:21], rs [20:16], rt [15:11], shamt [10:6], funct [2:0], imm21 [20:0], off16 [15:0].
REQ-018 DECODE SHALL latch A<=R[rs] and B<=R[rt], then go to EXEC.
REQ-019 R0 SHALL always read 0.
REQ-020 EXEC SHALL compute the result into ALUOUT, then go to WB.
REQ-021 For op=0 (R-type), funct SHALL select: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 SLL B<<shamt; 6 SRL B>>shamt (logical); 7 SLT (signed A<B, giving 1 or 0).
REQ-022 For op=1 (LI), the result SHALL be imm21 sign-extended from bit 20 to DATA_W, truncated when DATA_W<21.
REQ-023 For op=2 (BNZ), if A!=0 the next PC SHALL be PC+4+(sext(off16)<<2) mod 2^PC_W, otherwise PC+4; BNZ writes no register.
REQ-024 For op=3 (HALT), the core SHALL enter HALT without advancing PC and stay there until rst.
REQ-025 Any other op SHALL be illegal: no register write, PC+4, illegal=1 during its WB cycle.
REQ-026 In WB, ops 0 and 1 with rd!=0 SHALL write R[rd]<=ALUOUT and assert wb_valid, wb_reg and wb_data in the same cycle; writes to R0 SHALL leave the array unchanged with wb_valid=0.
REQ-027 WB SHALL update PC, then go to FETCH; with zero-wait ack, one instruction SHALL retire every 4 cycles.
REQ-028 Arithmetic SHALL wrap mod 2^DATA_W with no overflow flag; PC SHALL wrap from 2^PC_W-4 to 0.
REQ-029 In HALT, imem_req SHALL be 0, wb_valid SHALL be 0 and halted SHALL be 1.

Reset
REQ-030 When rst is sampled high, the core SHALL set state<=FETCH, PC<=0, IR, A, B, ALUOUT<=0 and every register<=0.
REQ-031 While rst is high, imem_req, wb_valid, illegal and halted SHALL be 0.
REQ-032 rst SHALL take priority over a pending ack, a write, a branch or HALT in any state.

Configuration
REQ-033 Macro MC_SHIFT_EN defined: funct 5 and 6 SHALL perform SLL and SRL as in REQ-021.
REQ-034 Macro MC_SHIFT_EN undefined: no shifter SHALL be built, and funct 5 and 6 SHALL be treated as illegal per REQ-025.

Verification
REQ-035 Reset, then LI r1 with imm21=0x1FFFFB and zero-wait ack -> WB in the 4th cycle: wb_reg=1, wb_data=0xFFFFFFFB; next imem_addr=4.
REQ-036 LI r1,7; LI r2,3; SUB r3,r1,r2; SLT r4,r2,r1; ADD r0,r1,r2 -> wb_data 4 then 1; the ADD gives wb_valid=0.
REQ-037 imem_ack delayed 3 cycles -> imem_req held high and imem_addr stable; 7 cycles per instruction.
REQ-038 BNZ at PC=8 with r1=7 and off16=0xFFFF -> next fetch at 8; with r1=0 -> 12; branch at PC=252 with off16=0 (PC_W=8) -> next fetch at 0.
REQ-039 SLL r5 with B=3, shamt=4 -> wb_data=48 with MC_SHIFT_EN; without it -> illegal pulse, wb_valid=0, next PC+4.
REQ-040 HALT -> halted=1 and imem_req=0 for 20 cycles; rst asserted mid-EXEC -> next cycle FETCH at imem_addr=0 and r1 reads 0.
